// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: resolves load-use, mul/div
// occupancy, data-memory wait and taken-branch hazards into PC/pipeline-register controls.
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic        i_id_uses_rs,
  input  logic        i_id_uses_rt,
  input  logic        i_id_muldiv,
  input  logic        i_id_reads_hilo,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_memRead,
  input  logic        i_ex_regWrite,
  input  logic        i_branch_taken,
  input  logic        i_dmem_busy,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_idex_en,
  output logic        o_exmem_en,
  output logic        o_memwb_en,
  output logic        o_ifid_flush,
  output logic        o_idex_flush,
  output logic        o_muldiv_busy,
  output logic [15:0] o_stall_count
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t  state;
  logic [3:0] cnt;
  logic       freeze;
  logic       load_use;
  logic       md_hazard;
  logic       stall;
  logic       md_issue;

  assign freeze   = i_dmem_busy;
  assign load_use = i_ex_memRead & i_ex_regWrite & (i_ex_rd != 5'd0) &
                    ((i_id_uses_rs & (i_rs == i_ex_rd)) |
                     (i_id_uses_rt & (i_rt == i_ex_rd)));

  // Busy is masked during reset so the controls come up clean on the reset cycle itself.
  assign o_muldiv_busy = (state == BUSY) & ~i_rst;
  assign md_hazard     = o_muldiv_busy & (i_id_muldiv | i_id_reads_hilo);
  assign stall         = load_use | md_hazard;
  assign md_issue      = i_id_muldiv & ~freeze & ~i_branch_taken & ~stall;

  always_comb begin
    o_pc_en      = 1'b1;
    o_ifid_en    = 1'b1;
    o_idex_en    = 1'b1;
    o_exmem_en   = 1'b1;
    o_memwb_en   = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    if (i_rst) begin
      o_pc_en = 1'b1;
    end else if (freeze) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_en  = 1'b0;
      o_exmem_en = 1'b0;
      o_memwb_en = 1'b0;
    end else if (i_branch_taken) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (stall) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

  // The mul/div unit runs independently of the pipeline, so a freeze does not pause it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (md_issue) begin
            state <= BUSY;
            cnt   <= 4'(MULDIV_LAT - 1);
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_count <= 16'd0;
    end else if (!o_pc_en && (o_stall_count != 16'hFFFF)) begin
      o_stall_count <= o_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push hand-computed expectations,
// a monitor process samples the DUT mid-cycle and compares against the queue head.
module tb_hazard_stall_unit;

  localparam logic [7:0] NORM   = 8'b11111000;
  localparam logic [7:0] STALL  = 8'b00111010;
  localparam logic [7:0] BRANCH = 8'b11111110;
  localparam logic [7:0] FREEZE = 8'b00000000;
  localparam logic [7:0] BUSYB  = 8'b00000001;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic [15:0] count;
  } expect_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_rs, i_rt, i_ex_rd;
  logic        i_id_uses_rs, i_id_uses_rt, i_id_muldiv, i_id_reads_hilo;
  logic        i_ex_memRead, i_ex_regWrite, i_branch_taken, i_dmem_busy;
  logic        o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
  logic        o_ifid_flush, o_idex_flush, o_muldiv_busy;
  logic [15:0] o_stall_count;

  expect_t expQ[$];
  int      checksDone = 0;
  int      checksPassed = 0;

  hazard_stall_unit #(.MULDIV_LAT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rs(i_rs), .i_rt(i_rt),
    .i_id_uses_rs(i_id_uses_rs), .i_id_uses_rt(i_id_uses_rt),
    .i_id_muldiv(i_id_muldiv), .i_id_reads_hilo(i_id_reads_hilo),
    .i_ex_rd(i_ex_rd), .i_ex_memRead(i_ex_memRead), .i_ex_regWrite(i_ex_regWrite),
    .i_branch_taken(i_branch_taken), .i_dmem_busy(i_dmem_busy),
    .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_idex_en(o_idex_en),
    .o_exmem_en(o_exmem_en), .o_memwb_en(o_memwb_en),
    .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_muldiv_busy(o_muldiv_busy), .o_stall_count(o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    checksDone++;
    if (actual === required) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
  endtask

  // Drive one cycle of inputs on the falling edge; optionally queue its expected response.
  task automatic applyStimulus(input string name, input logic rst, input logic dmem,
                               input logic br, input logic md, input logic hilo,
                               input logic exLoad, input logic [4:0] exRd,
                               input logic [4:0] rs, input logic usesRs,
                               input logic [4:0] rt, input logic usesRt,
                               input logic [7:0] ctrl, input logic [15:0] count,
                               input logic doCheck);
    expect_t e;
    @(negedge i_clk);
    i_rst = rst; i_dmem_busy = dmem; i_branch_taken = br;
    i_id_muldiv = md; i_id_reads_hilo = hilo;
    i_ex_memRead = exLoad; i_ex_regWrite = exLoad; i_ex_rd = exRd;
    i_rs = rs; i_id_uses_rs = usesRs; i_rt = rt; i_id_uses_rt = usesRt;
    if (doCheck) begin
      e.name = name; e.ctrl = ctrl; e.count = count;
      expQ.push_back(e);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, ".ctrl"},
                    {8'h00, o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
                     o_ifid_flush, o_idex_flush, o_muldiv_busy}, {8'h00, e.ctrl});
        checkOutput({e.name, ".count"}, o_stall_count, e.count);
      end
    end
  end

  initial begin : stimulus
    i_rst = 1'b1; i_dmem_busy = 1'b0; i_branch_taken = 1'b0;
    i_id_muldiv = 1'b0; i_id_reads_hilo = 1'b0; i_ex_memRead = 1'b0;
    i_ex_regWrite = 1'b0; i_ex_rd = 5'd0; i_rs = 5'd0; i_rt = 5'd0;
    i_id_uses_rs = 1'b0; i_id_uses_rt = 1'b0;

    //            name           rst dmem br md hl ld exRd  rs uRs rt uRt  ctrl  cnt  chk
    applyStimulus("rst0",        1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 0);
    applyStimulus("rst1",        1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 1);
    applyStimulus("normal",      0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 1);
    applyStimulus("lu_rs",       0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd2, 1, STALL, 16'd0, 1);
    applyStimulus("lu_after",    0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd2, 1, NORM, 16'd1, 1);
    applyStimulus("lu_rd0",      0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, NORM, 16'd1, 1);
    applyStimulus("lu_rt",       0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, STALL, 16'd1, 1);
    applyStimulus("lu_rt_unused",0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, NORM, 16'd2, 1);
    applyStimulus("br_lu",       0, 0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, BRANCH, 16'd2, 1);
    applyStimulus("br_md",       0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, BRANCH, 16'd2, 1);
    applyStimulus("br_md_after", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd2, 1);
    // mult at cycle 0, mflo waits through cycles 1..3 and goes at cycle 4
    applyStimulus("md_issue",    0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd2, 1);
    applyStimulus("mflo_c1",     0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd2, 1);
    applyStimulus("mflo_c2",     0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd3, 1);
    applyStimulus("mflo_c3",     0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd4, 1);
    applyStimulus("mflo_c4",     0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd5, 1);
    // freeze inside a busy window with a branch held across it
    applyStimulus("fz_issue",    0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd5, 1);
    applyStimulus("fz_c1",       0, 1, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, FREEZE | BUSYB, 16'd5, 1);
    applyStimulus("fz_c2",       0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, FREEZE | BUSYB, 16'd6, 1);
    applyStimulus("fz_c3",       0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, FREEZE | BUSYB, 16'd7, 1);
    applyStimulus("fz_br",       0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, BRANCH, 16'd8, 1);
    applyStimulus("fz_after",    0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd8, 1);
    // reset in the middle of a busy window
    applyStimulus("rb_issue",    0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd8, 1);
    applyStimulus("rb_busy",     0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM | BUSYB, 16'd8, 1);
    applyStimulus("rb_rst",      1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd8, 1);
    applyStimulus("rb_after",    0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 1);
    // a second muldiv waits out the first and issues on the first idle cycle
    applyStimulus("md2_issue",   0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 1);
    applyStimulus("md2_c1",      0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd0, 1);
    applyStimulus("md2_c2",      0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd1, 1);
    applyStimulus("md2_c3",      0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, STALL | BUSYB, 16'd2, 1);
    applyStimulus("md2_c4",      0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd3, 1);
    applyStimulus("md2_busy",    0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM | BUSYB, 16'd3, 1);
    // 65540 freeze cycles from a count of 3 saturates the counter
    for (int i = 0; i < 65540; i++)
      applyStimulus("sat_fill",  0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, FREEZE, 16'd0, 0);
    applyStimulus("sat_freeze",  0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, FREEZE, 16'hFFFF, 1);
    applyStimulus("sat_hold",    0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'hFFFF, 1);
    applyStimulus("idle",        0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, NORM, 16'd0, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge i_clk);
    if (expQ.size() > 0) begin
      checksDone++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall/flush controller for the 5-stage MIPS core, the counterpart to operand forwarding. Forwarding steers already-produced results into EX. This block handles every case where the result does not exist yet or the instruction stream is wrong:
- load-use hazards
- busy multi-cycle multiply/divide unit
- data-memory wait
- taken branches

It sits beside the ID stage and drives the PC and pipeline-register enable/flush controls.

## Interface
- MULDIV_LAT, 4, mul/div latency in cycles, legal range 2..15
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_rs, i_rt  in  5 each  ID-stage source registers
- i_id_uses_rs, i_id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- i_id_muldiv  in  1  ID instruction is mult/multu/div/divu
- i_id_reads_hilo  in  1  ID instruction is mfhi/mflo
- i_ex_rd  in  5  destination register of the EX-stage instruction
- i_ex_memRead, i_ex_regWrite  in  1 each  EX instruction is a load / writes the register file
- i_branch_taken  in  1  branch/jump resolved taken in EX
- i_dmem_busy  in  1  data memory not ready; freeze the pipeline
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1 each  register enables
- o_ifid_flush, o_idex_flush  out  1 each  load a bubble (NOP) into IF/ID or ID/EX
- o_muldiv_busy  out  1  mul/div unit occupied
- o_stall_count  out  16  saturating count of cycles with o_pc_en=0

## Operation
Hazard conditions:
- load_use = i_ex_memRead & i_ex_regWrite & i_ex_rd!=0 & ((i_id_uses_rs & i_rs==i_ex_rd) | (i_id_uses_rt & i_rt==i_ex_rd)).
- md_hazard = o_muldiv_busy & (i_id_muldiv | i_id_reads_hilo).

Priority, highest first:
1. **Freeze** (i_dmem_busy=1):
   - All five enables = 0; both flushes = 0.
   - Mul/div counter keeps counting. The unit is independent of the pipeline.
   - A branch, load_use or md_hazard in the same cycle is held, not acted on. It is re-evaluated when the freeze ends.
2. **Branch** (i_branch_taken=1):
   - o_pc_en=1, o_ifid_flush=1, o_idex_flush=1.
   - All other enables = 1.
   - A muldiv in ID is discarded and does not start the unit.
3. **Stall** (load_use | md_hazard):
   - o_pc_en=0, o_ifid_en=0, o_idex_flush=1.
   - o_exmem_en=o_memwb_en=o_idex_en=1.
4. **Normal**: all enables 1, flushes 0.

Mul/div FSM (registered state + 4-bit counter `cnt`):
- **IDLE**: if i_id_muldiv & not freeze & not branch & not stall → load cnt=MULDIV_LAT-1, go to BUSY.
- **BUSY**: each cycle cnt decrements.
  - At cnt==1 → IDLE on the next edge.
  - BUSY therefore lasts exactly MULDIV_LAT-1 cycles after the issue cycle.
- o_muldiv_busy = (state==BUSY).
- A second muldiv or mfhi/mflo in ID during BUSY stalls (md_hazard). It issues in the first cycle the state is IDLE.

Stall counter:
- Increments on every edge where o_pc_en=0 and i_rst=0.
- Saturates at 16'hFFFF.

Reset, while i_rst=1:
- Next state IDLE, cnt=0, o_stall_count=0.
- Outputs forced to: all enables 1, flushes 0, o_muldiv_busy 0.
- Reset asserted mid-BUSY returns to IDLE on that edge. The in-flight mul/div result is abandoned.

## Timing
- All enable/flush outputs are combinational from the inputs and registered state, with zero-cycle latency. They are valid before the same rising edge.
- Load-use inserts exactly one bubble. The next cycle the load is in MEM, the condition drops and forwarding supplies the value.
- Back-to-back loads each feeding the next instruction produce one bubble per pair, never two in a row for the same consumer.
- A branch flush lasts one cycle. Branch + load_use in the same cycle gives a flush, not a stall, and the stall counter does not increment.
- i_dmem_busy held N cycles freezes exactly N cycles. The stall counter increments N times.
- o_muldiv_busy rises one cycle after the issue edge and falls MULDIV_LAT-1 cycles later.

## Test plan
- **Load-use:** EX: memRead=1, regWrite=1, rd=5; ID: rs=5, uses_rs=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle, with no load in EX, everything is 1/0. Repeat with rd=0 → no stall.
- **Branch priority:** branch_taken=1 with a simultaneous load-use → pc_en=1, ifid_flush=1, idex_flush=1, stall_count unchanged.
- **Mul/div, MULDIV_LAT=4:**
  - mult in ID at cycle 0 → busy=1 for cycles 1..3, busy=0 at cycle 4.
  - mflo in ID from cycle 1 → stalled cycles 1..3, issues at cycle 4. stall_count=3.
- **Freeze:** dmem_busy=1 for 3 cycles during a BUSY window → all enables 0, flushes 0, counter still expires on schedule. A branch_taken held across the freeze is acted on in the first cycle after it.
- **Reset mid-operation:** i_rst=1 during BUSY with stall_count=7 → next cycle busy=0, stall_count=0, all enables 1.
- **Saturation:** force 65540 stall cycles → o_stall_count=16'hFFFF and holds.
